stream_tx_serializer: RTL

- Sits between core_interface's 32-bit stream output and the SPI transmit byte path in front of the instruction handler.
- Buffers stream words in a small FIFO.
- Presents them to the SPI byte interface one byte at a time, MSB byte first.
- Advances one byte per completed SPI byte transfer (rx-valid strobe), so the host MCU can read back multi-word results across consecutive SPI bytes.

---
 rtl/stream_tx_serializer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/stream_tx_serializer.sv
// -----------------------------------------------------------------------------
// stream_tx_serializer
//
// Buffers 32-bit stream words from core_interface in a small FIFO and presents
// them to the SPI transmit byte path one byte at a time, MSB byte first. Each
// completed SPI byte transfer (spi_rx_valid_i pulse) advances to the next byte.
// After the fourth byte of a word, the word is retired. This lets the host MCU
// read multi-word results across consecutive SPI bytes.
//
// Stream handshake: a word transfers on a rising clk_i edge when
// stream_valid_i && stream_ready_o. stream_ready_o depends only on the
// registered level (it is !full_o). A word offered while not ready is dropped
// and recorded in overflow_o. The producer is not expected to hold it.
//
// Ports:
//   clk_i           system clock; all logic on its rising edge
//   rst_ni          asynchronous active-low reset (synchronous release upstream)
//   stream_i        word from core_interface
//   stream_valid_i  stream_i holds a word to enqueue this cycle
//   stream_ready_o  FIFO can accept a word (== !full_o)
//   spi_rx_valid_i  one-cycle pulse per completed SPI byte
//   flush_i         synchronous clear of FIFO, byte index and sticky flags
//   tx_byte_o       byte to load into the SPI interface for the next transfer
//   level_o         number of words held
//   empty_o         level_o == 0
//   full_o          level_o == DEPTH
//   underflow_o     sticky: a strobe arrived while empty
//   overflow_o      sticky: a valid word was offered while full
// -----------------------------------------------------------------------------
module stream_tx_serializer #(
   parameter int          DEPTH     = 4,
   parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [31:0]                stream_i,
   input  logic                       stream_valid_i,
   output logic                       stream_ready_o,
   input  logic                       spi_rx_valid_i,
   input  logic                       flush_i,
   output logic [7:0]                 tx_byte_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       underflow_o,
   output logic                       overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

   // ---------------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------------
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, wr_ptr_next;
   logic [AW-1:0] rd_ptr, rd_ptr_next;
   logic [LW-1:0] level, level_next;
   logic [1:0]    idx, idx_next;
   logic          underflow, underflow_next;
   logic          overflow, overflow_next;

   // ---------------------------------------------------------------------------
   // Status decode (from registered level only)
   // ---------------------------------------------------------------------------
   logic empty;
   logic full;
   logic push;
   logic pop;
   logic advance;

   assign empty = (level == '0);
   assign full  = (level == LEVEL_FULL);

   // Acceptance uses the pre-edge level. A pop on the same edge does not free
   // a slot for the push, so a full FIFO always rejects the offered word.
   assign push    = stream_valid_i && !full && !flush_i;

   // A strobe only moves the byte index when there is a word to read from.
   assign advance = spi_rx_valid_i && !empty && !flush_i;
   assign pop     = advance && (idx == 2'd3);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_ptr_next    = wr_ptr;
      rd_ptr_next    = rd_ptr;
      level_next     = level;
      idx_next       = idx;
      underflow_next = underflow;
      overflow_next  = overflow;

      if (flush_i) begin
         // Flush wins over everything. Same-cycle push and strobe are discarded
         // and leave no trace in the sticky flags.
         wr_ptr_next    = '0;
         rd_ptr_next    = '0;
         level_next     = '0;
         idx_next       = 2'd0;
         underflow_next = 1'b0;
         overflow_next  = 1'b0;
      end else begin
         if (push) begin
            // DEPTH is a power of two, so the pointer wraps naturally.
            wr_ptr_next = wr_ptr + AW'(1);
         end

         if (advance) begin
            // idx is 2 bits, so 3 + 1 wraps back to byte 0 of the next word.
            idx_next = idx + 2'd1;
         end

         if (pop) begin
            rd_ptr_next = rd_ptr + AW'(1);
         end

         unique case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
         endcase

         if (spi_rx_valid_i && empty) begin
            underflow_next = 1'b1;
         end

         if (stream_valid_i && full) begin
            overflow_next = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         idx       <= 2'd0;
         underflow <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_next;
         rd_ptr    <= rd_ptr_next;
         level     <= level_next;
         idx       <= idx_next;
         underflow <= underflow_next;
         overflow  <= overflow_next;
      end
   end

   // Word storage is not reset. Its contents are only visible through the
   // level/pointer state, which is reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= stream_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Byte presentation: combinational from registered state
   // ---------------------------------------------------------------------------
   logic [31:0] head;
   assign head = mem[rd_ptr];

   always_comb begin
      tx_byte_o = IDLE_BYTE;
      if (!empty) begin
         unique case (idx)
            2'd0:    tx_byte_o = head[31:24];
            2'd1:    tx_byte_o = head[23:16];
            2'd2:    tx_byte_o = head[15:8];
            default: tx_byte_o = head[7:0];
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign stream_ready_o = !full;
   assign level_o        = level;
   assign empty_o        = empty;
   assign full_o         = full;
   assign underflow_o    = underflow;
   assign overflow_o     = overflow;

endmodule
